// File: rtl/midori_shuffle_mix_key.sv
// Midori128 round back-end: ShuffleCell, MixColumn and round-key XOR over two
// valid/ready register stages. A per-transaction last flag reduces it to a key-add.
module midori_shuffle_mix_key (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last
);

  // t_i = s_Perm[i]; cell 0 is the most significant byte.
  localparam int unsigned Perm [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};

  logic [7:0]   s_cell [16];
  logic [7:0]   t_cell [16];
  logic [7:0]   m_cell [16];
  logic [7:0]   col_xor;
  logic [127:0] mix_state;

  logic         s1_valid_q;
  logic [127:0] s1_data_q;
  logic [127:0] s1_key_q;
  logic         s1_last_q;
  logic         out_valid_q;
  logic [127:0] out_state_q;
  logic         out_last_q;

  logic         accept;
  logic         advance;

  always_comb begin
    s_cell    = '{default: '0};
    t_cell    = '{default: '0};
    m_cell    = '{default: '0};
    col_xor   = '0;
    mix_state = '0;
    for (int i = 0; i < 16; i++) begin
      s_cell[i] = in_state[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) begin
      t_cell[i] = s_cell[Perm[i]];
    end
    // XOR of the whole column then cancel the cell itself leaves the other three.
    for (int j = 0; j < 4; j++) begin
      col_xor = t_cell[4*j] ^ t_cell[4*j+1] ^ t_cell[4*j+2] ^ t_cell[4*j+3];
      for (int k = 0; k < 4; k++) begin
        m_cell[4*j+k] = col_xor ^ t_cell[4*j+k];
      end
    end
    for (int i = 0; i < 16; i++) begin
      mix_state[127-8*i -: 8] = in_last ? s_cell[i] : m_cell[i];
    end
  end

  always_comb begin
    advance  = s1_valid_q & (~out_valid_q | out_ready);
    in_ready = ~s1_valid_q | advance;
    accept   = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_key_q   <= '0;
      s1_last_q  <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= mix_state;
      s1_key_q   <= in_key;
      s1_last_q  <= in_last;
    end else if (advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_state_q <= '0;
      out_last_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= 1'b1;
      out_state_q <= s1_data_q ^ s1_key_q;
      out_last_q  <= s1_last_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/midori_shuffle_mix_key.md
Name: midori_shuffle_mix_key

Overview:
- Pipelined Midori128 round back-end. Sits directly downstream of the SubCell stage and consumes its 128-bit output.
- Applies ShuffleCell, then MixColumn, then the round-key XOR.
- Two register stages with valid/ready flow control, so the round datapath can be iterated or chained under backpressure.
- A per-transaction "last" flag bypasses ShuffleCell and MixColumn. This implements the final whitening key-add.

Parameters:
- None. Widths are fixed by Midori128: 128-bit state, sixteen 8-bit cells.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_state, in_key and in_last are valid.
- in_ready  output  1  block can accept an input this cycle.
- in_state  input  128  SubCell output state.
- in_key  input  128  round key for this transaction.
- in_last  input  1  1 = final round: skip ShuffleCell and MixColumn, key-add only.
- out_valid  output  1  out_state is valid.
- out_ready  input  1  downstream accepts out_state this cycle.
- out_state  output  128  round result.
- out_last  output  1  in_last carried with the transaction.

Behaviour:
- Cell numbering: cell i = state[127-8i : 120-8i]. Cell 0 is the most significant byte. Columns are cells {4j..4j+3}, j = 0..3.
- ShuffleCell: t_i = s_{P(i)}, with P = [0,10,5,15,14,4,11,1,9,3,12,6,7,13,2,8].
- MixColumn, per column: m_{4j+k} = XOR of the other three cells of that column (cells 4j..4j+3 excluding 4j+k).
- Bypass: if in_last = 1, m = in_state unchanged.
- Stage 1, on accept (in_valid & in_ready): registers s1_data = m, s1_key = in_key, s1_last = in_last, and sets s1_valid.
- Stage 2, on advance: registers out_state = s1_data XOR s1_key and out_last = s1_last, and sets out_valid.
- All arithmetic is bitwise XOR. There are no carries.
- Latency: 2 cycles from accept to out_valid when there is no stall. Throughput is 1 transaction per cycle when out_ready is held at 1.
- Handshake:
  - Stage 2 advances when s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | stage-2 advance. This is a combinational path from out_ready.
  - out_valid clears on out_ready when no new data advances into stage 2.
  - Simultaneous out_ready and advance: out_state is replaced in the same edge and out_valid stays 1.
  - A held output is stable: out_state and out_last do not change while out_valid & !out_ready.
- Full condition: both stages valid and out_ready = 0. in_ready = 0, no input is accepted, nothing is dropped or duplicated.
- Empty condition: in_ready = 1 and out_valid = 0.
- Input data is sampled only on the accept edge. in_state and in_key may change freely when not accepted.
- Reset (rst_n = 0 at a clock edge), including mid-operation:
  - s1_valid = 0, out_valid = 0, out_last = 0, out_state = 128'h0.
  - In-flight data is discarded.
  - in_ready reads 1 in the first cycle after reset releases.
- Reset has priority over a simultaneous accept.

Test Plan:
- Cell-0 mix: in_state = 128'h01000000_00000000_00000000_00000000, key = 0, last = 0 -> after 2 cycles out_state = 128'h00010101_00000000_00000000_00000000, out_last = 0.
- Shuffle routing: in_state = 128'h000000AB (cell 15 = 0xAB, rest 0), key = 0, last = 0 -> out_state = 128'hABABAB00_00000000_00000000_00000000.
- Final-round bypass: in_state = 128'h01000000_0...0, key = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, last = 1 -> out_state = 128'hFEFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, out_last = 1.
- Backpressure:
  - Stimulus: out_ready = 0, offer 3 back-to-back distinct transactions.
  - Required: exactly 2 accepted, then in_ready = 0 and out_state stays stable.
  - Then raise out_ready = 1: the 3 outputs appear in order over consecutive cycles with no loss.
- Streaming: 16 transactions with in_valid = 1 and out_ready = 1 -> one output per cycle starting at cycle 2, matching the reference model in order.
- Reset mid-operation: with both stages full, assert rst_n = 0 for 1 cycle -> out_valid = 0, out_state = 0, in_ready = 1 after reset; no stale output ever appears.
